// File: rtl/v_cache_pkg.sv
// Shared helpers for the vector cache dispatch path: field-width calculations.
package v_cache_pkg;

  // Index width for an N-entry selector; a single entry still needs one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must represent 0..max_val inclusive.
  function automatic int unsigned cnt_w(int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/v_bank_dispatch_ctrl_if.sv
// Request, issue and credit-return bundle between the front-end, the dispatcher and the banks.
interface v_bank_dispatch_ctrl_if
  import v_cache_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PLD_W = 32
);

  localparam int unsigned IdxW = idx_w(N);
  localparam int unsigned CntW = cnt_w(DEPTH);

  logic             in_vld;
  logic             in_rdy;
  logic [IdxW-1:0]  in_idx;
  logic [PLD_W-1:0] in_pld;
  logic [N-1:0]     out_vld;
  logic [PLD_W-1:0] out_pld;
  logic [N-1:0]     crd_rtn;
  logic [CntW-1:0]  q_cnt;
  logic             crd_err;

  // Request source and bank side.
  modport master (
    output in_vld, in_idx, in_pld, crd_rtn,
    input  in_rdy, out_vld, out_pld, q_cnt, crd_err
  );

  // Dispatcher side.
  modport slave (
    input  in_vld, in_idx, in_pld, crd_rtn,
    output in_rdy, out_vld, out_pld, q_cnt, crd_err
  );

endinterface

// File: rtl/v_1toN_decode.sv
// Gated binary-to-one-hot decoder driving the per-bank valid bus.
module v_1toN_decode
  import v_cache_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                 en_i,
  input  logic [idx_w(N)-1:0]  idx_i,
  output logic [N-1:0]         onehot_o
);

  // At most one bit set, and none unless enabled.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/v_bank_dispatch_ctrl.sv
// In-order credit-based dispatcher: queues {idx, pld} requests and issues the head to its bank
// only while that bank holds a credit. Younger requests wait behind a blocked head.
module v_bank_dispatch_ctrl
  import v_cache_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CREDIT = 2,
  parameter int unsigned PLD_W  = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  v_bank_dispatch_ctrl_if.slave bus
);

  localparam int unsigned IdxW = idx_w(N);
  localparam int unsigned PtrW = idx_w(DEPTH);
  localparam int unsigned CntW = cnt_w(DEPTH);
  localparam int unsigned CrdW = cnt_w(CREDIT);

  typedef struct packed {
    logic [IdxW-1:0]  idx;
    logic [PLD_W-1:0] pld;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] q_cnt_q, q_cnt_d;
  logic [CrdW-1:0] crd_q [N];
  logic [CrdW-1:0] crd_d [N];
  logic            crd_err_q, crd_err_d;

  entry_t          head;
  logic [IdxW-1:0] head_idx;
  logic            in_rdy;
  logic            push;
  logic            issue;

  // Head selection and handshake; issue depends on registered state only.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    head_idx = head.idx;
    in_rdy   = (q_cnt_q != CntW'(DEPTH));
    push     = bus.in_vld && in_rdy;
    issue    = (q_cnt_q != '0) && (crd_q[head_idx] != '0);
  end

  // FIFO next state; a full queue refuses input even while popping.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    q_cnt_d  = q_cnt_q + CntW'(push) - CntW'(issue);
    if (push) begin
      mem_d[wr_ptr_q] = '{idx: bus.in_idx, pld: bus.in_pld};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  // Per-bank credits: issue consumes, return refills, both together cancel out.
  always_comb begin
    crd_err_d = crd_err_q;
    for (int unsigned i = 0; i < N; i++) begin
      crd_d[i] = crd_q[i];
      if (issue && (head_idx == IdxW'(i))) begin
        if (!bus.crd_rtn[i]) begin
          crd_d[i] = crd_q[i] - CrdW'(1);
        end
      end else if (bus.crd_rtn[i]) begin
        if (crd_q[i] == CrdW'(CREDIT)) begin
          crd_err_d = 1'b1;  // overflowing return is dropped but remembered
        end else begin
          crd_d[i] = crd_q[i] + CrdW'(1);
        end
      end
    end
  end

  // State registers; reset empties the queue and restores every credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      for (int unsigned i = 0; i < N; i++) begin
        crd_q[i] <= CrdW'(CREDIT);
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      q_cnt_q   <= '0;
      crd_err_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      crd_q     <= crd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      q_cnt_q   <= q_cnt_d;
      crd_err_q <= crd_err_d;
    end
  end

  v_1toN_decode #(
    .N (N)
  ) u_decode (
    .en_i     (issue),
    .idx_i    (head_idx),
    .onehot_o (bus.out_vld)
  );

  assign bus.in_rdy  = in_rdy;
  assign bus.out_pld = head.pld;
  assign bus.q_cnt   = q_cnt_q;
  assign bus.crd_err = crd_err_q;

endmodule
